time_display_mux: RTL and testbench

Downstream consumer of the real-time clock stage. Takes the binary hours/mins/secs and the buzzer flag and drives a multiplexed 6-digit common-anode 7-segment display (HH.MM.SS).
Per-frame snapshot prevents digit tearing. Anode guard interval suppresses ghosting. Whole display blinks while the alarm buzzer is active.

---
 rtl/time_pkg.sv | 58 +++++
 rtl/seg7_encode.sv | 26 ++
 rtl/time_display_mux.sv | 154 +++++++++++++++
 tb/tb_time_display_mux.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - shared field widths, limits, digit indices and BCD helpers
// for the time display.
package time_pkg;

  localparam int HOURS_W    = 5;
  localparam int MINS_W     = 6;
  localparam int SECS_W     = 6;
  localparam int NUM_DIGITS = 6;

  localparam logic [5:0] MAX_HOURS     = 6'd23;
  localparam logic [5:0] MAX_MINS_SECS = 6'd59;

  localparam logic [2:0] DIG_SECS_U  = 3'd0;
  localparam logic [2:0] DIG_SECS_T  = 3'd1;
  localparam logic [2:0] DIG_MINS_U  = 3'd2;
  localparam logic [2:0] DIG_MINS_T  = 3'd3;
  localparam logic [2:0] DIG_HOURS_U = 3'd4;
  localparam logic [2:0] DIG_HOURS_T = 3'd5;

  localparam logic [3:0] DASH  = 4'd10;
  localparam logic [3:0] BLANK = 4'd15;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_t;

  // Comparison ladder instead of a divider; only valid for v <= 59.
  function automatic bcd_t split_bcd(input logic [5:0] v);
    bcd_t r;
    if (v >= 6'd50) begin
      r.tens = 4'd5; r.units = 4'(v - 6'd50);
    end else if (v >= 6'd40) begin
      r.tens = 4'd4; r.units = 4'(v - 6'd40);
    end else if (v >= 6'd30) begin
      r.tens = 4'd3; r.units = 4'(v - 6'd30);
    end else if (v >= 6'd20) begin
      r.tens = 4'd2; r.units = 4'(v - 6'd20);
    end else if (v >= 6'd10) begin
      r.tens = 4'd1; r.units = 4'(v - 6'd10);
    end else begin
      r.tens = 4'd0; r.units = v[3:0];
    end
    return r;
  endfunction

  function automatic bcd_t field_digits(input logic [5:0] v, input logic [5:0] max_v);
    bcd_t r;
    if (v > max_v) begin
      r.tens  = DASH;
      r.units = DASH;
    end else begin
      r = split_bcd(v);
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// rtl/seg7_encode.sv - 4-bit code to active-high {g,f,e,d,c,b,a} segments;
// 0-9 digits, 10 dash, 11-15 blank.
module seg7_encode (
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b0000000;
    case (code)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      4'd10:   seg = 7'b1000000;
      default: seg = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/time_display_mux.sv
// rtl/time_display_mux.sv - 6-digit multiplexed HH.MM.SS display driver with
// per-frame snapshot, anode guard blanking and buzzer blink.
module time_display_mux
  import time_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int GUARD          = 16,
  parameter int BLINK_TICKS    = 250,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [HOURS_W-1:0]    hours,
  input  logic [MINS_W-1:0]     mins,
  input  logic [SECS_W-1:0]     secs,
  input  logic                  buzzer,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GUARD_END  = CW'(GUARD);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_IDLE = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0] SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
  localparam logic DP_IDLE = (SEG_ACTIVE_LOW != 0);

  logic [CW-1:0]         scan_cnt_q, scan_cnt_d;
  logic [2:0]            digit_idx_q, digit_idx_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic                  first_q, first_d;
  logic [HOURS_W-1:0]    snap_hours_q, snap_hours_d;
  logic [MINS_W-1:0]     snap_mins_q, snap_mins_d;
  logic [SECS_W-1:0]     snap_secs_q, snap_secs_d;
  logic                  snap_buzzer_q, snap_buzzer_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  slot_end, frame_end;
  logic [3:0]            code;
  logic [6:0]            seg_hi;
  logic [NUM_DIGITS-1:0] an_act;
  logic                  dp_act;
  bcd_t                  hr_bcd, mn_bcd, sc_bcd;

  always_comb begin
    slot_end  = (scan_cnt_q == SCAN_LAST);
    frame_end = slot_end && (digit_idx_q == DIG_HOURS_T);

    scan_cnt_d  = slot_end ? '0 : scan_cnt_q + CW'(1);
    digit_idx_d = digit_idx_q;
    if (slot_end) digit_idx_d = frame_end ? DIG_SECS_U : digit_idx_q + 3'd1;

    // Snapshot on the first edge out of reset and whenever a new frame starts.
    first_d       = 1'b0;
    snap_hours_d  = snap_hours_q;
    snap_mins_d   = snap_mins_q;
    snap_secs_d   = snap_secs_q;
    snap_buzzer_d = snap_buzzer_q;
    if (first_q || frame_end) begin
      snap_hours_d  = hours;
      snap_mins_d   = mins;
      snap_secs_d   = secs;
      snap_buzzer_d = buzzer;
    end

    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (!snap_buzzer_q) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (slot_end) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  always_comb begin
    hr_bcd = field_digits({1'b0, snap_hours_q}, MAX_HOURS);
    mn_bcd = field_digits(snap_mins_q, MAX_MINS_SECS);
    sc_bcd = field_digits(snap_secs_q, MAX_MINS_SECS);
    code   = BLANK;
    case (digit_idx_q)
      DIG_SECS_U:  code = sc_bcd.units;
      DIG_SECS_T:  code = sc_bcd.tens;
      DIG_MINS_U:  code = mn_bcd.units;
      DIG_MINS_T:  code = mn_bcd.tens;
      DIG_HOURS_U: code = hr_bcd.units;
      DIG_HOURS_T: code = hr_bcd.tens;
      default:     code = BLANK;
    endcase
  end

  seg7_encode u_seg7_encode (
    .code (code),
    .seg  (seg_hi)
  );

  always_comb begin
    an_act = '0;
    if ((scan_cnt_q >= GUARD_END) && en && !(snap_buzzer_q && blink_phase_q))
      an_act = NUM_DIGITS'(1) << digit_idx_q;
    dp_act = (digit_idx_q == DIG_MINS_U) || (digit_idx_q == DIG_HOURS_U);
    an_d   = (AN_ACTIVE_LOW != 0) ? ~an_act : an_act;
    seg_d  = (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
    dp_d   = (SEG_ACTIVE_LOW != 0) ? ~dp_act : dp_act;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt_q    <= '0;
      digit_idx_q   <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      first_q       <= 1'b1;
      snap_hours_q  <= '0;
      snap_mins_q   <= '0;
      snap_secs_q   <= '0;
      snap_buzzer_q <= 1'b0;
      an_q          <= AN_IDLE;
      seg_q         <= SEG_IDLE;
      dp_q          <= DP_IDLE;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      digit_idx_q   <= digit_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      first_q       <= first_d;
      snap_hours_q  <= snap_hours_d;
      snap_mins_q   <= snap_mins_d;
      snap_secs_q   <= snap_secs_d;
      snap_buzzer_q <= snap_buzzer_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_time_display_mux.sv
// tb/tb_time_display_mux.sv - scoreboard bench for time_display_mux against a
// frame/slot arithmetic reference model.
module tb_time_display_mux;

  localparam int SD    = 4;
  localparam int GD    = 1;
  localparam int BT    = 3;
  localparam int FRAME = 6 * SD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       buzzer = 1'b0;
  logic [4:0] hours = 5'd0;
  logic [5:0] mins = 6'd0;
  logic [5:0] secs = 6'd0;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  time_display_mux #(
    .SCAN_DIV       (SD),
    .GUARD          (GD),
    .BLINK_TICKS    (BT),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .hours  (hours),
    .mins   (mins),
    .secs   (secs),
    .buzzer (buzzer),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Active-high {g,f,e,d,c,b,a} for digits 0..9.
  logic [6:0] seg_tab [0:9] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66,
                                7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};

  int m_n = 0;
  int m_r = 0;
  bit m_first = 1'b1;
  int m_h = 0, m_m = 0, m_s = 0;
  bit m_buz = 1'b0;

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%b exp=%b at t=%0t", name, got, exp, $time);
  endtask

  function automatic out_t predict(input bit en_now);
    out_t       o;
    int         scan, idx, field, limit, d;
    logic [5:0] onehot;
    logic [6:0] segh;
    bit         lit;
    scan  = m_n % SD;
    idx   = (m_n / SD) % 6;
    field = (idx < 2) ? m_s : (idx < 4) ? m_m : m_h;
    limit = (idx < 4) ? 59 : 23;
    d     = (idx % 2 == 1) ? field / 10 : field % 10;
    segh  = (field > limit) ? 7'h40 : seg_tab[d];
    lit   = (scan >= GD) && en_now && !(m_buz && ((m_r / BT) % 2 == 1));
    onehot = 6'(1 << idx);
    o.an  = lit ? ~onehot : 6'h3f;
    o.seg = ~segh;
    o.dp  = !(idx == 2 || idx == 4);
    return o;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_n = 0; m_r = 0; m_first = 1'b1;
      m_h = 0; m_m = 0; m_s = 0; m_buz = 1'b0;
      exp_q.delete();
    end else begin
      exp_q.push_back(predict(en));
      if (!m_buz) m_r = 0;
      else if (m_n % SD == SD - 1) m_r++;
      if (m_first || ((m_n + 1) % FRAME == 0)) begin
        m_h = int'(hours); m_m = int'(mins); m_s = int'(secs); m_buz = buzzer;
      end
      m_first = 1'b0;
      m_n++;
    end
  end

  always @(negedge clk) begin
    out_t e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '{an: 6'h3f, seg: 7'h7f, dp: 1'b1};
    check("an", {1'b0, an}, {1'b0, e.an});
    check("seg", seg, e.seg);
    check("dp", {6'b0, dp}, {6'b0, e.dp});
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    bit found;
    hours = 5'($urandom_range(0, 23));
    mins  = 6'($urandom_range(0, 59));
    secs  = 6'($urandom_range(0, 59));
    step(3);
    reset = 1'b0;
    for (int c = 0; c < 30; c++) begin
      hours = 5'($urandom_range(0, 31));
      secs  = 6'($urandom_range(0, 63));
      step(1);
    end

    en = 1'b1; hours = 5'd13; mins = 6'd45; secs = 6'd7;
    step(2 * FRAME);

    found = 1'b0;
    for (int k = 0; k < 2 * FRAME && !found; k++) begin
      if ((m_n / SD) % 6 == 3) found = 1'b1;
      else step(1);
    end
    check("sync_idx3", {6'b0, found}, 7'd1);
    secs = 6'd8;
    step(2 * FRAME);

    hours = 5'd24; mins = 6'd60; secs = 6'($urandom_range(0, 59));
    step(2 * FRAME);

    hours = 5'd9; mins = 6'd30; buzzer = 1'b1;
    step(4 * FRAME);
    buzzer = 1'b0;
    step(2 * FRAME);

    found = 1'b0;
    for (int k = 0; k < 2 * FRAME && !found; k++) begin
      if ((m_n / SD) % 6 == 3 && m_n % SD == 2) found = 1'b1;
      else step(1);
    end
    check("sync_idx3_scan2", {6'b0, found}, 7'd1);
    #1 reset = 1'b1;
    hours = 5'd22; mins = 6'd11; secs = 6'd59;
    #1;
    check("rst_an", {1'b0, an}, 7'h3f);
    check("rst_seg", seg, 7'h7f);
    check("rst_dp", {6'b0, dp}, 7'd1);
    step(2);
    reset = 1'b0;
    step(2 * FRAME);

    buzzer = 1'b1;
    for (int c = 0; c < 800; c++) begin
      step(1);
      if ($urandom_range(0, 7) == 0) hours = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) mins = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) secs = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 59) == 0) en = ~en;
      if ($urandom_range(0, 99) == 0) buzzer = ~buzzer;
    end

    step(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
